// File: rtl/can_crc_check.sv
// can_crc_check: frame CRC and stuff-count checker for the CAN / CAN FD receive path.
// Runs CRC-15/17/21 LFSRs over destuffed frame bits (SOF up to the CRC field),
// collects the classic CRC-15 field and the FD stuff count, and compares them
// against the received values.
// Optional feature macro: CAN_CRC_STUFF_CNT_EN (stuff counter + stuff-count check).
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   bit_en, data, stuff_bit, sof,    destuffed bit stream and per-bit qualifiers
//   crc_seq_start
//   crc_end                          FD CRC field captured upstream
//   abort                            drop the frame, back to IDLE
//   fd_frame, crc21_sel              frame type, latched at crc_seq_start
//   en_FD_iso                        ISO CAN FD mode
//   rx_crc_17_i, rx_crc_21_i         received FD CRCs from the CRC-field destuffer
//   check_done                       one-cycle verdict strobe
//   crc_error, stuff_cnt_error       verdict, held until next sof or abort
//   busy                             frame in progress
module can_crc_check (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bit_en,
    input  logic        data,
    input  logic        stuff_bit,
    input  logic        sof,
    input  logic        crc_seq_start,
    input  logic        crc_end,
    input  logic        abort,
    input  logic        fd_frame,
    input  logic        crc21_sel,
    input  logic        en_FD_iso,
    input  logic [16:0] rx_crc_17_i,
    input  logic [20:0] rx_crc_21_i,
    output logic        check_done,
    output logic        crc_error,
    output logic        stuff_cnt_error,
    output logic        busy
);

    localparam logic [14:0] POLY15 = 15'h4599;
    localparam logic [16:0] POLY17 = 17'h1685B;
    localparam logic [20:0] POLY21 = 21'h102899;

    typedef enum logic [2:0] {IDLE, CALC, SCNT, RXCRC, CHECK} state_t;

    state_t      state;
    logic [14:0] crc15;
    logic [16:0] crc17;
    logic [20:0] crc21;
    logic [14:0] rx_crc15;
    logic [3:0]  bit_cnt;
    logic        fd_lat;
    logic        sel21_lat;
    logic [16:0] init17;
    logic [20:0] init21;

    function automatic logic [14:0] upd15(input logic [14:0] c, input logic d);
        return {c[13:0], 1'b0} ^ ((d ^ c[14]) ? POLY15 : 15'd0);
    endfunction

    function automatic logic [16:0] upd17(input logic [16:0] c, input logic d);
        return {c[15:0], 1'b0} ^ ((d ^ c[16]) ? POLY17 : 17'd0);
    endfunction

    function automatic logic [20:0] upd21(input logic [20:0] c, input logic d);
        return {c[19:0], 1'b0} ^ ((d ^ c[20]) ? POLY21 : 21'd0);
    endfunction

    // ISO CAN FD seeds the FD CRCs with a leading one
    assign init17 = en_FD_iso ? 17'h10000 : 17'd0;
    assign init21 = en_FD_iso ? 21'h100000 : 21'd0;

`ifdef CAN_CRC_STUFF_CNT_EN
    logic [2:0] stuff_cnt;
    logic [3:0] scnt_rx;
    logic       scnt_used;
    logic [2:0] gray;
    logic [3:0] scnt_exp;

    // Gray-coded count plus even parity over all four bits
    assign gray     = {stuff_cnt[2], stuff_cnt[2] ^ stuff_cnt[1], stuff_cnt[1] ^ stuff_cnt[0]};
    assign scnt_exp = {gray, ^gray};
`else
    assign stuff_cnt_error = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            crc15      <= '0;
            crc17      <= '0;
            crc21      <= '0;
            rx_crc15   <= '0;
            bit_cnt    <= '0;
            fd_lat     <= 1'b0;
            sel21_lat  <= 1'b0;
            check_done <= 1'b0;
            crc_error  <= 1'b0;
            busy       <= 1'b0;
`ifdef CAN_CRC_STUFF_CNT_EN
            stuff_cnt       <= '0;
            scnt_rx         <= '0;
            scnt_used       <= 1'b0;
            stuff_cnt_error <= 1'b0;
`endif
        end else begin
            check_done <= 1'b0;
            if (abort) begin
                state     <= IDLE;
                busy      <= 1'b0;
                crc_error <= 1'b0;
`ifdef CAN_CRC_STUFF_CNT_EN
                stuff_cnt_error <= 1'b0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (bit_en && sof) begin
                            state     <= CALC;
                            busy      <= 1'b1;
                            crc15     <= upd15(15'd0, data);
                            crc17     <= upd17(init17, data);
                            crc21     <= upd21(init21, data);
                            crc_error <= 1'b0;
`ifdef CAN_CRC_STUFF_CNT_EN
                            stuff_cnt       <= '0;
                            stuff_cnt_error <= 1'b0;
`endif
                        end
                    end
                    CALC: begin
                        if (bit_en) begin
                            if (crc_seq_start) begin
                                fd_lat    <= fd_frame;
                                sel21_lat <= crc21_sel;
                                bit_cnt   <= 4'd1;
`ifdef CAN_CRC_STUFF_CNT_EN
                                scnt_used <= fd_frame & en_FD_iso;
                                scnt_rx   <= {3'b000, data};
`endif
                                if (fd_frame && en_FD_iso) begin
                                    // first stuff-count bit is covered by the FD CRCs
                                    state <= SCNT;
                                    crc17 <= upd17(crc17, data);
                                    crc21 <= upd21(crc21, data);
                                end else begin
                                    // first CRC bit, not fed to the LFSRs
                                    state    <= RXCRC;
                                    rx_crc15 <= {rx_crc15[13:0], data};
                                end
                            end else begin
                                if (!stuff_bit) begin
                                    crc15 <= upd15(crc15, data);
                                end
                                if (!stuff_bit || en_FD_iso) begin
                                    crc17 <= upd17(crc17, data);
                                    crc21 <= upd21(crc21, data);
                                end
`ifdef CAN_CRC_STUFF_CNT_EN
                                if (stuff_bit) begin
                                    stuff_cnt <= stuff_cnt + 3'd1;
                                end
`endif
                            end
                        end
                    end
                    SCNT: begin
                        if (bit_en) begin
                            crc17 <= upd17(crc17, data);
                            crc21 <= upd21(crc21, data);
`ifdef CAN_CRC_STUFF_CNT_EN
                            scnt_rx <= {scnt_rx[2:0], data};
`endif
                            if (bit_cnt == 4'd3) begin
                                state <= RXCRC;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    RXCRC: begin
                        if (fd_lat) begin
                            if (crc_end) begin
                                state <= CHECK;
                            end
                        end else if (bit_en) begin
                            rx_crc15 <= {rx_crc15[13:0], data};
                            if (bit_cnt == 4'd14) begin
                                state <= CHECK;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    CHECK: begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        check_done <= 1'b1;
                        if (!fd_lat) begin
                            crc_error <= (rx_crc15 != crc15);
                        end else if (sel21_lat) begin
                            crc_error <= (rx_crc_21_i != crc21);
                        end else begin
                            crc_error <= (rx_crc_17_i != crc17);
                        end
`ifdef CAN_CRC_STUFF_CNT_EN
                        stuff_cnt_error <= scnt_used && (scnt_rx != scnt_exp);
`endif
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_can_crc_check.sv
// Self-checking bench for can_crc_check: directed scenarios plus randomized
// frames, checked against a polynomial long-division CRC model and a
// table-based stuff-count model.
module tb_can_crc_check;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bit_en;
    logic        data;
    logic        stuff_bit;
    logic        sof;
    logic        crc_seq_start;
    logic        crc_end;
    logic        abort;
    logic        fd_frame;
    logic        crc21_sel;
    logic        en_FD_iso;
    logic [16:0] rx_crc_17_i;
    logic [20:0] rx_crc_21_i;
    logic        check_done;
    logic        crc_error;
    logic        stuff_cnt_error;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // model state for the frame in progress
    bit q15[$];
    bit qfd[$];
    int nstuff;
    bit cur_iso;

    localparam logic [20:0] P15 = 21'h004599;
    localparam logic [20:0] P17 = 21'h01685B;
    localparam logic [20:0] P21 = 21'h102899;

    always #5 clk = ~clk;

    can_crc_check dut (
        .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .data(data),
        .stuff_bit(stuff_bit), .sof(sof), .crc_seq_start(crc_seq_start),
        .crc_end(crc_end), .abort(abort), .fd_frame(fd_frame),
        .crc21_sel(crc21_sel), .en_FD_iso(en_FD_iso),
        .rx_crc_17_i(rx_crc_17_i), .rx_crc_21_i(rx_crc_21_i),
        .check_done(check_done), .crc_error(crc_error),
        .stuff_cnt_error(stuff_cnt_error), .busy(busy)
    );

    // Remainder of (init * x^n + msg * x^w) modulo (x^w + poly), by long division
    function automatic logic [20:0] ref_crc(input int w, input logic [20:0] poly,
                                            input logic [20:0] init, input bit msg[$]);
        bit d[$];
        logic [20:0] r;
        int n;
        n = msg.size();
        d = msg;
        for (int i = 0; i < w; i++) d.push_back(1'b0);
        for (int i = 0; i < w; i++) d[i] = d[i] ^ init[w-1-i];
        for (int i = 0; i < n; i++) begin
            if (d[i]) begin
                d[i] = 1'b0;
                for (int j = 0; j < w; j++) d[i+1+j] = d[i+1+j] ^ poly[w-1-j];
            end
        end
        r = '0;
        for (int j = 0; j < w; j++) r[w-1-j] = d[n+j];
        return r;
    endfunction

    function automatic logic [3:0] exp_scnt(input int cnt);
        logic [2:0] gray_tab [8];
        logic [2:0] g;
        int ones;
        gray_tab = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
        g = gray_tab[cnt % 8];
        ones = int'(g[0]) + int'(g[1]) + int'(g[2]);
        return {g, ((ones % 2) == 1) ? 1'b1 : 1'b0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic d, input logic st, input logic s, input logic cs);
        data = d; stuff_bit = st; sof = s; crc_seq_start = cs; bit_en = 1'b1;
        tick();
        bit_en = 1'b0; stuff_bit = 1'b0; sof = 1'b0; crc_seq_start = 1'b0;
    endtask

    task automatic gap();
        repeat ($urandom_range(2)) tick();
    endtask

    task automatic start_frame(input bit iso, input bit sofbit);
        en_FD_iso = iso;
        cur_iso = iso;
        q15.delete();
        qfd.delete();
        nstuff = 0;
        send(sofbit, 1'b0, 1'b1, 1'b0);
        q15.push_back(sofbit);
        qfd.push_back(sofbit);
    endtask

    // random body bits; a stray sof inside the frame is just another bit
    task automatic body(input int n, input int stuff_pct);
        bit d, st, s;
        for (int i = 0; i < n; i++) begin
            d  = 1'($urandom_range(1));
            st = ($urandom_range(99) < stuff_pct);
            s  = ($urandom_range(9) == 0);
            gap();
            send(d, st, s, 1'b0);
            if (!st) q15.push_back(d);
            if (!st || cur_iso) qfd.push_back(d);
            if (st) nstuff++;
        end
    endtask

    task automatic verdict(input string tag, input bit exp_ce, input bit exp_se);
        chk({tag, "_busy_in_check"}, 32'(busy), 32'd1);
        chk({tag, "_done_early"}, 32'(check_done), 32'd0);
        tick();
        chk({tag, "_done"}, 32'(check_done), 32'd1);
        chk({tag, "_crc_err"}, 32'(crc_error), 32'(exp_ce));
        chk({tag, "_scnt_err"}, 32'(stuff_cnt_error), 32'(exp_se));
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
        tick();
        chk({tag, "_done_pulse"}, 32'(check_done), 32'd0);
        chk({tag, "_crc_err_held"}, 32'(crc_error), 32'(exp_ce));
    endtask

    task automatic finish_classic(input logic [14:0] rx, input string tag);
        logic [14:0] e;
        e = 15'(ref_crc(15, P15, 21'd0, q15));
        fd_frame = 1'b0;
        crc21_sel = 1'($urandom_range(1));
        send(rx[14], 1'b0, 1'b0, 1'b1);
        for (int i = 13; i >= 0; i--) begin
            gap();
            send(rx[i], 1'b0, 1'b0, 1'b0);
        end
        verdict(tag, rx != e, 1'b0);
    endtask

    // scnt_flip / f17 / f21 are error masks applied to the correct values
    task automatic finish_fd(input bit sel21, input logic [3:0] scnt_flip,
                             input logic [16:0] f17, input logic [20:0] f21,
                             input string tag);
        logic [3:0]  sc;
        logic [16:0] e17;
        logic [20:0] e21;
        bit          exp_se;
        fd_frame  = 1'b1;
        crc21_sel = sel21;
        sc = exp_scnt(nstuff) ^ scnt_flip;
        if (cur_iso) begin
            send(sc[3], 1'b0, 1'b0, 1'b1);
            qfd.push_back(sc[3]);
            for (int i = 2; i >= 0; i--) begin
                gap();
                send(sc[i], 1'b0, 1'b0, 1'b0);
                qfd.push_back(sc[i]);
            end
        end else begin
            send(1'($urandom_range(1)), 1'b0, 1'b0, 1'b1);
        end
        // extra strobes in the FD CRC field must be ignored
        send(1'($urandom_range(1)), 1'b0, 1'b0, 1'b0);
        e17 = 17'(ref_crc(17, P17, cur_iso ? 21'h010000 : 21'd0, qfd));
        e21 = ref_crc(21, P21, cur_iso ? 21'h100000 : 21'd0, qfd);
        rx_crc_17_i = e17 ^ f17;
        rx_crc_21_i = e21 ^ f21;
        gap();
        crc_end = 1'b1;
        tick();
        crc_end = 1'b0;
`ifdef CAN_CRC_STUFF_CNT_EN
        exp_se = cur_iso && (scnt_flip != 4'd0);
`else
        exp_se = 1'b0;
`endif
        verdict(tag, sel21 ? (f21 != 21'd0) : (f17 != 17'd0), exp_se);
    endtask

    initial begin
        logic [14:0] e15;
        int mode;
        rst_n = 1'b0; bit_en = 1'b0; data = 1'b0; stuff_bit = 1'b0; sof = 1'b0;
        crc_seq_start = 1'b0; crc_end = 1'b0; abort = 1'b0; fd_frame = 1'b0;
        crc21_sel = 1'b0; en_FD_iso = 1'b0; rx_crc_17_i = '0; rx_crc_21_i = '0;
        cur_iso = 1'b0; nstuff = 0;

        // reset state
        repeat (2) tick();
        chk("rst_done", 32'(check_done), 32'd0);
        chk("rst_crc_err", 32'(crc_error), 32'd0);
        chk("rst_scnt_err", 32'(stuff_cnt_error), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick();

        // classic: SOF=1 only gives CRC-15 = 4599
        start_frame(1'b0, 1'b1);
        chk("busy_after_sof", 32'(busy), 32'd1);
        finish_classic(15'h4599, "cls_match");
        start_frame(1'b0, 1'b1);
        chk("sof_clears_err", 32'(crc_error), 32'd0);
        finish_classic(15'h4598, "cls_bad");

        // error held in IDLE, then cleared by abort
        repeat (3) tick();
        chk("err_held_idle", 32'(crc_error), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_clears_err", 32'(crc_error), 32'd0);

        // FD ISO, CRC-17, zero stuff count
        start_frame(1'b1, 1'b0);
        finish_fd(1'b0, 4'd0, 17'd0, 21'd0, "fd17_ok");
        start_frame(1'b1, 1'b0);
        finish_fd(1'b0, 4'd0, 17'd1, 21'd0, "fd17_bit0");

        // five stuff bits: count field 1111
        start_frame(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            send(1'b1, 1'b1, 1'b0, 1'b0);
            qfd.push_back(1'b1);
            nstuff++;
        end
        chk("scnt5_model", 32'(exp_scnt(nstuff)), 32'hF);
        finish_fd(1'b0, 4'd0, 17'd0, 21'd0, "scnt5_ok");
        start_frame(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            send(1'b0, 1'b1, 1'b0, 1'b0);
            qfd.push_back(1'b0);
            nstuff++;
        end
        finish_fd(1'b0, 4'b0001, 17'd0, 21'd0, "scnt5_bad");

        // CRC-21 selected: wrong CRC-17 must not matter
        start_frame(1'b1, 1'b0);
        body(20, 10);
        finish_fd(1'b1, 4'd0, 17'h00100, 21'd0, "fd21_sel");

        // abort together with crc_end in RXCRC
        start_frame(1'b1, 1'b1);
        body(8, 20);
        fd_frame = 1'b1;
        crc21_sel = 1'b0;
        for (int i = 0; i < 4; i++) send(1'b1, 1'b0, 1'b0, (i == 0));
        abort = 1'b1;
        crc_end = 1'b1;
        tick();
        abort = 1'b0;
        crc_end = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(check_done), 32'd0);
        chk("abort_crc_err", 32'(crc_error), 32'd0);
        chk("abort_scnt_err", 32'(stuff_cnt_error), 32'd0);
        tick();
        chk("abort_no_done_later", 32'(check_done), 32'd0);

        // reset mid-CALC
        start_frame(1'b0, 1'b1);
        body(6, 0);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(check_done), 32'd0);
        chk("midrst_crc_err", 32'(crc_error), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        start_frame(1'b0, 1'b0);
        body(12, 15);
        e15 = 15'(ref_crc(15, P15, 21'd0, q15));
        finish_classic(e15, "post_rst");

        // randomized frames
        for (int f = 0; f < 24; f++) begin
            mode = $urandom_range(2);
            if (mode == 0) begin
                start_frame(1'($urandom_range(1)), 1'($urandom_range(1)));
                body($urandom_range(60, 10), 15);
                e15 = 15'(ref_crc(15, P15, 21'd0, q15));
                if ($urandom_range(2) == 0) e15 = e15 ^ (15'd1 << $urandom_range(14));
                finish_classic(e15, "rnd_cls");
            end else begin
                start_frame(mode == 1, 1'($urandom_range(1)));
                body($urandom_range(60, 10), 15);
                finish_fd(1'($urandom_range(1)),
                          ($urandom_range(3) == 0) ? 4'(1 << $urandom_range(3)) : 4'd0,
                          ($urandom_range(2) == 0) ? 17'(1 << $urandom_range(16)) : 17'd0,
                          ($urandom_range(2) == 0) ? 21'(1 << $urandom_range(20)) : 21'd0,
                          (mode == 1) ? "rnd_fd_iso" : "rnd_fd_noniso");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/can_crc_check.md
# can_crc_check

Frame CRC and stuff-count checker for the CAN / CAN FD receive path. It runs the CRC-15, CRC-17 and CRC-21 LFSRs serially over destuffed frame bits from SOF up to the CRC field. It also counts dynamic stuff bits, collects the classic CRC-15 field, and compares everything against the received values. The FD CRC fields come from the CRC-field destuffer, and the verdict is handed to the receive controller. Sits directly downstream of the bit destuffer and alongside the CRC-field destuffer, consuming its `crc_17_o`/`crc_21_o`.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- bit_en  in  1  one-cycle strobe; the current `data` bit is valid this cycle
- data  in  1  received bit (post sample point)
- stuff_bit  in  1  with `bit_en`: current bit is a dynamic stuff bit
- sof  in  1  with `bit_en`: current bit is SOF; starts a frame
- crc_seq_start  in  1  with `bit_en`: first bit after the data field
- crc_end  in  1  one-cycle pulse; the FD CRC field has been fully captured upstream
- abort  in  1  frame error / bus-off; return to IDLE
- fd_frame  in  1  frame is FD (latched at `crc_seq_start`)
- crc21_sel  in  1  FD data length > 16 bytes; use CRC-21 (latched at `crc_seq_start`)
- en_FD_iso  in  1  ISO CAN FD mode
- rx_crc_17_i  in  17  received CRC-17 from the CRC-field destuffer
- rx_crc_21_i  in  21  received CRC-21 from the CRC-field destuffer
- check_done  out  1  one-cycle pulse; the verdict outputs are valid
- crc_error  out  1  CRC mismatch; held until the next `sof` or `abort`
- stuff_cnt_error  out  1  stuff-count mismatch; held until the next `sof` or `abort`
- busy  out  1  state != IDLE

## Operation
States: IDLE, CALC, SCNT, RXCRC, CHECK.

Transitions:
- **IDLE → CALC** on `bit_en & sof`.
  - LFSR initial values: CRC-15 = 0. CRC-17 = 17'h10000 if `en_FD_iso`, else 0. CRC-21 = 21'h100000 if `en_FD_iso`, else 0.
  - The stuff counter and the error outputs are cleared.
  - The SOF bit is clocked into all LFSRs.
- **In CALC**, for each `bit_en`:
  - If `stuff_bit` = 0, all LFSRs update.
  - If `stuff_bit` = 1, CRC-15 holds. CRC-17/21 update only when `en_FD_iso`. The stuff counter increments mod 8.
- **CALC → SCNT** on `bit_en & crc_seq_start` when `fd_frame & en_FD_iso`. The `crc_seq_start` bit itself is the first stuff-count bit.
- **CALC → RXCRC** on `bit_en & crc_seq_start` otherwise. The bit is the first CRC bit and is not fed to the LFSRs.
- **SCNT**: 4 bits (3 Gray bits MSB first, then parity).
  - Bits shift into `scnt_rx[3:0]` and also into CRC-17/21.
  - After the 4th bit → RXCRC.
- **RXCRC, classic**: 15 CRC bits shift into `rx_crc15`, MSB first. The bit entering RXCRC counts as bit 1. After the 15th bit → CHECK.
- **RXCRC, FD**: ignore `bit_en`; on `crc_end` → CHECK.
- **CHECK** lasts one cycle, then → IDLE. Compares:
  - classic: `rx_crc15` vs CRC-15
  - FD with `crc21_sel`: `rx_crc_21_i` vs CRC-21
  - FD otherwise: `rx_crc_17_i` vs CRC-17
- **abort** in any state → IDLE next edge. Outputs cleared, no `check_done`.
- **sof** outside IDLE is ignored.

LFSR update, W ∈ {15, 17, 21}:
- n = `data` ^ crc[W-1]
- crc = {crc[W-2:0], 1'b0} ^ (n ? POLY : 0)
- POLY15 = 15'h4599, POLY17 = 17'h1685B, POLY21 = 21'h102899

Stuff-count expected value:
- Gray(cnt) for cnt 0..7 = 000, 001, 011, 010, 110, 111, 101, 100
- Parity bit makes the total number of ones in the 4 bits even.

## Timing
- All registers reset asynchronously on `rst_n` = 0. Outputs reset to `check_done` = 0, `crc_error` = 0, `stuff_cnt_error` = 0, `busy` = 0. State resets to IDLE and the LFSRs to 0.
- Reset mid-frame discards the frame silently.
- State and LFSRs update on the `clk` edge where `bit_en` = 1. `data`, `stuff_bit`, `sof` and `crc_seq_start` are sampled only in that cycle.
- Verdict latency: the final bit edge (or `crc_end` edge) enters CHECK. The next edge registers `check_done` = 1 together with the errors. Latency is 2 edges.
- `check_done` is high for exactly 1 cycle. `crc_error` and `stuff_cnt_error` stay asserted until `sof` or `abort`.
- `rx_crc_17_i`/`rx_crc_21_i` are sampled in the CHECK cycle only.
- `abort` has priority over `crc_end` and `bit_en` in the same cycle.

## Configuration
- `CAN_CRC_STUFF_CNT_EN` defined: the stuff counter and stuff-count comparison are present. `stuff_cnt_error` = 1 in CHECK when `fd_frame & en_FD_iso` and `scnt_rx` ≠ {Gray(cnt), parity}.
- Undefined: the counter and comparison are removed and `stuff_cnt_error` is tied 0. The SCNT state still consumes 4 bits and feeds them to CRC-17/21.

## Test plan
- **Classic, CRC-15 match:** SOF bit 1, then 15 zero CRC bits → CRC-15 = 15'h4599. Receive 15'h4599 → `check_done` pulse, `crc_error` = 0. Receive 15'h4598 → `crc_error` = 1.
- **FD ISO, CRC-17:** `en_FD_iso` = 1, SOF bit 0, `crc_seq_start` next → SCNT. Send 0000 (cnt 0) → `stuff_cnt_error` = 0. Check CRC-17 against a model with `rx_crc_17_i` = model value → `crc_error` = 0. Flip bit 0 → `crc_error` = 1.
- **Stuff count:** 5 `stuff_bit` pulses in CALC. SCNT receives 1111 → no error. Receives 1110 → `stuff_cnt_error` = 1. With the macro undefined → 0.
- **CRC-21 select:** `crc21_sel` = 1; a correct `rx_crc_21_i` with a wrong `rx_crc_17_i` → `crc_error` = 0.
- **Abort:** `abort` during RXCRC together with `crc_end` → IDLE, no `check_done`, errors 0, `busy` = 0.
- **Reset:** `rst_n` low mid-CALC → all outputs 0 immediately. The next SOF restarts cleanly.
